// File: rtl/differpd_vote_pkg.sv
// Shared definitions for the bit-sync phase detectors: edge-mode codes, counter sizing, popcount.
// Pure constants and functions; no state, no latency, no flow control.
package differpd_vote_pkg;

  localparam int EDGE_BOTH = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_FALL = 2;

  // Two extra bits give the sign plus headroom for one cycle of NCH votes past LIMIT.
  function automatic int cnt_width(input int limit, input int nch);
    return $clog2(limit + nch) + 2;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/differpd_vote_edge_det.sv
// Per-channel transition detector: registers the data bit and flags the selected edge type.
// One cycle from sampled datain to din_edge; always accepts, no backpressure.
module pd_edge_det
  import differpd_vote_pkg::*;
#(
  parameter int EDGE_MODE = EDGE_BOTH
) (
  input  logic clk32,
  input  logic rst,
  input  logic din,
  output logic din_edge
);

  logic din_d_q;
  logic din_d_d;
  logic din_edge_q;
  logic din_edge_d;

  always_comb begin
    din_d_d    = din;
    din_edge_d = din ^ din_d_q;
    if (EDGE_MODE == EDGE_RISE) begin
      din_edge_d = din & ~din_d_q;
    end else if (EDGE_MODE == EDGE_FALL) begin
      din_edge_d = ~din & din_d_q;
    end
  end

  always_ff @(posedge clk32) begin
    if (rst) begin
      din_d_q    <= 1'b0;
      din_edge_q <= 1'b0;
    end else begin
      din_d_q    <= din_d_d;
      din_edge_q <= din_edge_d;
    end
  end

  assign din_edge = din_edge_q;

endmodule

// File: rtl/differpd_vote.sv
// Multi-channel early/late phase detector with random-walk loop filter feeding the DPLL.
// Pulse registered two edges after the launching edge of a datain change; no backpressure.
module differpd_vote
  import differpd_vote_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int LIMIT     = 8,
  parameter int EDGE_MODE = EDGE_BOTH,
  localparam int CW       = cnt_width(LIMIT, NCH)
) (
  input  logic                 clk32,
  input  logic                 rst,
  input  logic [NCH-1:0]       datain,
  input  logic                 clk_i,
  input  logic                 clk_q,
  input  logic                 filt_en,
  output logic                 pd_bef,
  output logic                 pd_aft,
  output logic signed [CW-1:0] pd_cnt
);

  localparam int NW = CW + 1;
  localparam logic signed [CW:0] LIM_P = NW'(LIMIT);
  localparam logic signed [CW:0] LIM_N = -LIM_P;

  logic [NCH-1:0] edge_vec;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    pd_edge_det #(.EDGE_MODE(EDGE_MODE)) u_det (
      .clk32    (clk32),
      .rst      (rst),
      .din      (datain[g]),
      .din_edge (edge_vec[g])
    );
  end

  logic [7:0] edge_pad;
  logic [3:0] n_edge;
  logic [3:0] vb;
  logic [3:0] va;

  // Votes only count in the exclusive halves of the quadrature windows.
  always_comb begin
    edge_pad           = '0;
    edge_pad[NCH-1:0]  = edge_vec;
    n_edge             = popcount8(edge_pad);
    vb                 = (clk_i && !clk_q) ? n_edge : 4'd0;
    va                 = (clk_q && !clk_i) ? n_edge : 4'd0;
  end

  logic signed [CW-1:0] acc_q;
  logic signed [CW-1:0] acc_d;
  logic                 filt_en_d_q;
  logic                 filt_en_d_d;
  logic                 bef_q;
  logic                 bef_d;
  logic                 aft_q;
  logic                 aft_d;
  logic signed [CW:0]   nxt;

  always_comb begin
    nxt         = {acc_q[CW-1], acc_q} + signed'(NW'(vb)) - signed'(NW'(va));
    acc_d       = acc_q;
    bef_d       = 1'b0;
    aft_d       = 1'b0;
    filt_en_d_d = filt_en;
    if (filt_en != filt_en_d_q) begin
      // Mode switch: drop whatever was accumulated and stay silent this cycle.
      acc_d = '0;
    end else if (!filt_en_d_q) begin
      bef_d = (vb != 4'd0);
      aft_d = (va != 4'd0);
      acc_d = '0;
    end else if (nxt >= LIM_P) begin
      bef_d = 1'b1;
      acc_d = '0;
    end else if (nxt <= LIM_N) begin
      aft_d = 1'b1;
      acc_d = '0;
    end else begin
      acc_d = nxt[CW-1:0];
    end
  end

  always_ff @(posedge clk32) begin
    if (rst) begin
      acc_q       <= '0;
      filt_en_d_q <= 1'b0;
      bef_q       <= 1'b0;
      aft_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      filt_en_d_q <= filt_en_d_d;
      bef_q       <= bef_d;
      aft_q       <= aft_d;
    end
  end

  assign pd_bef = bef_q;
  assign pd_aft = aft_q;
  assign pd_cnt = acc_q;

endmodule

// File: tb/tb_differpd_vote.sv
// Bench for differpd_vote: directed scenarios then random traffic, two instances
// (both-edge LIMIT=8 and rising-only LIMIT=3) checked every cycle against a vote-counting model.
module tb_differpd_vote;
  import differpd_vote_pkg::*;

  localparam int NCH = 2;
  localparam int L0  = 8;
  localparam int L1  = 3;
  localparam int CW0 = cnt_width(L0, NCH);
  localparam int CW1 = cnt_width(L1, NCH);

  logic clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  logic                  rst;
  logic [NCH-1:0]        datain;
  logic                  clk_i;
  logic                  clk_q;
  logic                  filt_en;
  logic                  bef0, aft0, bef1, aft1;
  logic signed [CW0-1:0] cnt0;
  logic signed [CW1-1:0] cnt1;

  differpd_vote #(.NCH(NCH), .LIMIT(L0), .EDGE_MODE(EDGE_BOTH)) u_dut0 (
    .clk32(clk32), .rst(rst), .datain(datain), .clk_i(clk_i), .clk_q(clk_q),
    .filt_en(filt_en), .pd_bef(bef0), .pd_aft(aft0), .pd_cnt(cnt0)
  );

  differpd_vote #(.NCH(NCH), .LIMIT(L1), .EDGE_MODE(EDGE_RISE)) u_dut1 (
    .clk32(clk32), .rst(rst), .datain(datain), .clk_i(clk_i), .clk_q(clk_q),
    .filt_en(filt_en), .pd_bef(bef1), .pd_aft(aft1), .pd_cnt(cnt1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference: remembers the last data sample and the pending transition set, then
  // applies the early/late vote arithmetic of the loop filter directly on integers.
  typedef struct {
    int din_d;
    int edg;
    int acc;
    int fen_d;
    int bef;
    int aft;
  } mstate_t;

  mstate_t m [2];
  int      lim   [2] = '{L0, L1};
  int      emode [2] = '{EDGE_BOTH, EDGE_RISE};
  bit      chk_en = 1'b0;

  task automatic model_step(input int k);
    int n, vb, va, nxt, ne, d;
    d  = int'(datain);
    n  = $countones(m[k].edg);
    vb = (clk_i && !clk_q) ? n : 0;
    va = (clk_q && !clk_i) ? n : 0;
    case (emode[k])
      EDGE_RISE: ne = d & ~m[k].din_d & 3;
      EDGE_FALL: ne = ~d & m[k].din_d & 3;
      default:   ne = d ^ m[k].din_d;
    endcase
    if (rst) begin
      m[k] = '{default: 0};
    end else begin
      m[k].bef = 0;
      m[k].aft = 0;
      if (int'(filt_en) != m[k].fen_d) begin
        m[k].acc = 0;
      end else if (m[k].fen_d == 0) begin
        m[k].bef = (vb != 0);
        m[k].aft = (va != 0);
        m[k].acc = 0;
      end else begin
        nxt = m[k].acc + vb - va;
        if (nxt >= lim[k]) begin
          m[k].bef = 1;
          m[k].acc = 0;
        end else if (nxt <= -lim[k]) begin
          m[k].aft = 1;
          m[k].acc = 0;
        end else begin
          m[k].acc = nxt;
        end
      end
      m[k].din_d = d;
      m[k].edg   = ne;
      m[k].fen_d = int'(filt_en);
    end
  endtask

  always @(posedge clk32) begin
    for (int k = 0; k < 2; k++) model_step(k);
    if (rst) chk_en = 1'b1;
  end

  always @(negedge clk32) begin
    if (chk_en) begin
      chk("bef0", int'(bef0), m[0].bef);
      chk("aft0", int'(aft0), m[0].aft);
      chk("cnt0", int'(cnt0), m[0].acc);
      chk("excl0", int'(bef0 & aft0), 0);
      chk("bef1", int'(bef1), m[1].bef);
      chk("aft1", int'(aft1), m[1].aft);
      chk("cnt1", int'(cnt1), m[1].acc);
    end
  end

  task automatic cyc(input logic [1:0] d, input logic ci, input logic cq);
    @(negedge clk32);
    datain = d;
    clk_i  = ci;
    clk_q  = cq;
  endtask

  // Change data, then hold it so the vote lands in the same window.
  task automatic vote(input logic [1:0] d, input logic ci, input logic cq);
    cyc(d, ci, cq);
    cyc(d, ci, cq);
  endtask

  int ph;

  initial begin
    rst     = 1'b1;
    datain  = 2'b00;
    clk_i   = 1'b0;
    clk_q   = 1'b0;
    filt_en = 1'b0;

    // Reset with toggling data
    cyc(2'b01, 1'b1, 1'b0); @(negedge clk32);
    chk("rst_cnt", int'(cnt0), 0); chk("rst_bef", int'(bef0), 0); chk("rst_aft", int'(aft0), 0);
    cyc(2'b11, 1'b1, 1'b0); @(negedge clk32);
    chk("rst_cnt", int'(cnt0), 0); chk("rst_bef", int'(bef0), 0); chk("rst_aft", int'(aft0), 0);
    cyc(2'b00, 1'b0, 1'b1); @(negedge clk32);
    chk("rst_cnt", int'(cnt0), 0); chk("rst_bef", int'(bef0), 0); chk("rst_aft", int'(aft0), 0);
    rst = 1'b0;
    @(negedge clk32);
    chk("rel_bef", int'(bef0), 0); chk("rel_aft", int'(aft0), 0); chk("rel_cnt", int'(cnt0), 0);

    // Bypass: early then late raw pulse, one cycle wide
    vote(2'b01, 1'b1, 1'b0); @(negedge clk32);
    chk("byp_bef", int'(bef0), 1); chk("byp_bef_aft", int'(aft0), 0);
    @(negedge clk32);
    chk("byp_bef_1cyc", int'(bef0), 0);
    vote(2'b00, 1'b0, 1'b1); @(negedge clk32);
    chk("byp_aft", int'(aft0), 1); chk("byp_aft_bef", int'(bef0), 0);

    // Enter filter mode
    @(negedge clk32); filt_en = 1'b1;
    @(negedge clk32);
    vote(2'b11, 1'b1, 1'b0); vote(2'b00, 1'b1, 1'b0);
    vote(2'b11, 1'b1, 1'b0); vote(2'b00, 1'b1, 1'b0);
    @(negedge clk32);
    chk("flt8_bef", int'(bef0), 1); chk("flt8_cnt", int'(cnt0), 0);
    @(negedge clk32);
    chk("flt8_1cyc", int'(bef0), 0);

    // 7 early then 1 late
    vote(2'b11, 1'b1, 1'b0); vote(2'b00, 1'b1, 1'b0);
    vote(2'b11, 1'b1, 1'b0); vote(2'b10, 1'b1, 1'b0);
    vote(2'b11, 1'b0, 1'b1);
    @(negedge clk32);
    chk("walk6_cnt", int'(cnt0), 6); chk("walk6_bef", int'(bef0), 0);

    // Overshoot from +7 by two
    vote(2'b10, 1'b1, 1'b0); @(negedge clk32);
    chk("ovr_cnt7", int'(cnt0), 7);
    vote(2'b01, 1'b1, 1'b0); @(negedge clk32);
    chk("ovr_bef", int'(bef0), 1); chk("ovr_cnt", int'(cnt0), 0);

    // Mirror: down to -7, then two late votes
    vote(2'b10, 1'b0, 1'b1); vote(2'b01, 1'b0, 1'b1);
    vote(2'b10, 1'b0, 1'b1); vote(2'b11, 1'b0, 1'b1);
    @(negedge clk32);
    chk("mir_cnt-7", int'(cnt0), -7);
    vote(2'b00, 1'b0, 1'b1); @(negedge clk32);
    chk("mir_aft", int'(aft0), 1); chk("mir_bef", int'(bef0), 0); chk("mir_cnt", int'(cnt0), 0);

    // Window guard: clk_i = clk_q = 1 gives no vote
    vote(2'b01, 1'b1, 1'b0);
    vote(2'b10, 1'b1, 1'b1); @(negedge clk32);
    chk("guard_cnt", int'(cnt0), 1);

    // Mode switch at +5
    vote(2'b11, 1'b1, 1'b0); vote(2'b00, 1'b1, 1'b0); vote(2'b01, 1'b1, 1'b0);
    @(negedge clk32);
    chk("sw_cnt5", int'(cnt0), 5);
    filt_en = 1'b0;
    @(negedge clk32);
    chk("sw_cnt", int'(cnt0), 0); chk("sw_bef", int'(bef0), 0); chk("sw_aft", int'(aft0), 0);
    filt_en = 1'b1;
    @(negedge clk32);
    @(negedge clk32);

    // Reset mid-run at -6
    vote(2'b10, 1'b0, 1'b1); vote(2'b01, 1'b0, 1'b1); vote(2'b10, 1'b0, 1'b1);
    @(negedge clk32);
    chk("mr_cnt-6", int'(cnt0), -6);
    rst = 1'b1;
    @(negedge clk32);
    rst = 1'b0;
    chk("mr_cnt", int'(cnt0), 0); chk("mr_aft", int'(aft0), 0);
    @(negedge clk32);
    chk("mr_aft_post", int'(aft0), 0); chk("mr_cnt_post", int'(cnt0), 0);

    // Random traffic with quadrature windows from a divide-by-8 phase counter
    ph = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk32);
      ph     = (ph + 1) % 8;
      clk_i  = (ph < 4);
      clk_q  = (((ph + 2) % 8) < 4);
      if ($urandom_range(2) == 0) datain = 2'($urandom);
      if ($urandom_range(199) == 0) filt_en = ~filt_en;
      rst = ($urandom_range(499) == 0);
    end
    @(negedge clk32);
    rst = 1'b0;
    @(negedge clk32);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
